// File: rtl/mpmc9_req_queue.sv
// ----------------------------------------------------------------------------
// mpmc9_req_queue
//
// Per-channel request queue placed after the channel sync register stage.
// Each level-held bus cycle (cs_i high until the cycle ends) becomes exactly
// one queued entry. Entries are presented show-ahead to the channel arbiter
// over a valid/ready handshake. A cycle that starts while the queue is full is
// held pending until space frees, or dropped if the cycle is abandoned.
//
// Parameters:
//   W      data width in bits; byte-select width is W/8
//   DEPTH  number of entries (power of 2, at least 2)
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   cs_i            channel select, held high for the whole bus cycle
//   we_i, sel_i,
//   adr_i, dati_i,
//   sr_i, cr_i      request fields captured at push time
//   req_valid_o     head entry valid toward the arbiter
//   req_ready_i     arbiter accepts the head entry
//   we_o, sel_o,
//   adr_o, dato_o,
//   sr_o, cr_o      head entry fields (0 while empty)
//   count_o         entries held, 0..DEPTH
//   full_o, empty_o registered occupancy flags
//   pend_o          a cycle has started but is not yet enqueued
// ----------------------------------------------------------------------------
module mpmc9_req_queue #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,

    input  logic                         cs_i,
    input  logic                         we_i,
    input  logic [W/8-1:0]               sel_i,
    input  logic [31:0]                  adr_i,
    input  logic [W-1:0]                 dati_i,
    input  logic                         sr_i,
    input  logic                         cr_i,

    output logic                         req_valid_o,
    input  logic                         req_ready_i,
    output logic                         we_o,
    output logic [W/8-1:0]               sel_o,
    output logic [31:0]                  adr_o,
    output logic [W-1:0]                 dato_o,
    output logic                         sr_o,
    output logic                         cr_o,

    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         pend_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = W / 8;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_pend;
    logic          r_cs_prev;

    // Entry storage; not reset, since the outputs are masked while empty.
    logic          r_mem_we  [DEPTH];
    logic [SW-1:0] r_mem_sel [DEPTH];
    logic [31:0]   r_mem_adr [DEPTH];
    logic [W-1:0]  r_mem_dat [DEPTH];
    logic          r_mem_sr  [DEPTH];
    logic          r_mem_cr  [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic          w_start;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_pend_d;
    logic [CW-1:0] w_count_d;

    // Rising edge of the level-held select marks a new bus cycle.
    assign w_start    = cs_i & ~r_cs_prev;
    assign w_push_req = w_start | r_pend;
    assign w_pop      = ~r_empty & req_ready_i;
    // When full, a same-edge pop frees the slot the push will occupy.
    assign w_push     = w_push_req & cs_i & (~r_full | w_pop);

    always_comb begin
        w_pend_d = r_pend;
        if (w_push) begin
            w_pend_d = 1'b0;
        end else if (!cs_i) begin
            // Cycle abandoned upstream before it could be queued.
            w_pend_d = 1'b0;
        end else if (w_start) begin
            w_pend_d = 1'b1;
        end
    end

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_pend    <= 1'b0;
            r_cs_prev <= 1'b0;
        end else begin
            r_cs_prev <= cs_i;
            r_pend    <= w_pend_d;
            r_count   <= w_count_d;
            r_full    <= (w_count_d == CW'(DEPTH));
            r_empty   <= (w_count_d == '0);
            // DEPTH is a power of 2, so pointer overflow wraps naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_we [r_wr_ptr] <= we_i;
            r_mem_sel[r_wr_ptr] <= sel_i;
            r_mem_adr[r_wr_ptr] <= adr_i;
            r_mem_dat[r_wr_ptr] <= dati_i;
            r_mem_sr [r_wr_ptr] <= sr_i;
            r_mem_cr [r_wr_ptr] <= cr_i;
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead head outputs
    // ------------------------------------------------------------------------
    always_comb begin
        we_o   = 1'b0;
        sel_o  = '0;
        adr_o  = '0;
        dato_o = '0;
        sr_o   = 1'b0;
        cr_o   = 1'b0;
        if (!r_empty) begin
            we_o   = r_mem_we [r_rd_ptr];
            sel_o  = r_mem_sel[r_rd_ptr];
            adr_o  = r_mem_adr[r_rd_ptr];
            dato_o = r_mem_dat[r_rd_ptr];
            sr_o   = r_mem_sr [r_rd_ptr];
            cr_o   = r_mem_cr [r_rd_ptr];
        end
    end

    assign req_valid_o = ~r_empty;
    assign count_o     = r_count;
    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign pend_o      = r_pend;

    // ------------------------------------------------------------------------
    // Internal consistency checks
    // ------------------------------------------------------------------------
    a_count_range: assert property (@(posedge clk) disable iff (!rstn)
        r_count <= CW'(DEPTH));
    a_flags_match: assert property (@(posedge clk) disable iff (!rstn)
        (r_full == (r_count == CW'(DEPTH))) && (r_empty == (r_count == '0)));
    a_ptr_match: assert property (@(posedge clk) disable iff (!rstn)
        (r_count == '0 || r_count == CW'(DEPTH)) == (r_rd_ptr == r_wr_ptr));
    a_pend_only_full: assert property (@(posedge clk) disable iff (!rstn)
        r_pend |-> r_full);

endmodule

// File: tb/tb_mpmc9_req_queue.sv
// Self-checking bench for mpmc9_req_queue: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences for pending and reset cases.
module tb_mpmc9_req_queue;

    localparam int unsigned W     = 128;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SW    = W / 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic          cs_i;
    logic          we_i;
    logic [SW-1:0] sel_i;
    logic [31:0]   adr_i;
    logic [W-1:0]  dati_i;
    logic          sr_i;
    logic          cr_i;
    logic          req_valid_o;
    logic          req_ready_i;
    logic          we_o;
    logic [SW-1:0] sel_o;
    logic [31:0]   adr_o;
    logic [W-1:0]  dato_o;
    logic          sr_o;
    logic          cr_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          pend_o;

    int total;
    int bad;

    mpmc9_req_queue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cs_i        (cs_i),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .adr_i       (adr_i),
        .dati_i      (dati_i),
        .sr_i        (sr_i),
        .cr_i        (cr_i),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .we_o        (we_o),
        .sel_o       (sel_o),
        .adr_o       (adr_o),
        .dato_o      (dato_o),
        .sr_o        (sr_o),
        .cr_o        (cr_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .pend_o      (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          cs;
        logic          we;
        logic [SW-1:0] sel;
        logic [31:0]   adr;
        logic          sr;
        logic          cr;
        logic          rdy;
        int            e_cnt;
        logic          e_pend;
        logic          e_we;
        logic [SW-1:0] e_sel;
        logic [31:0]   e_adr;
        logic          e_sr;
        logic          e_cr;
    } vec_t;

    vec_t vecs[$];

    // Write data is a recognisable pattern of the address.
    function automatic logic [W-1:0] dpat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | a};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic [SW-1:0] sel,
                         input logic [31:0] adr, input logic sr, input logic cr,
                         input logic rdy);
        cs_i        = cs;
        we_i        = we;
        sel_i       = sel;
        adr_i       = adr;
        dati_i      = dpat(adr);
        sr_i        = sr;
        cr_i        = cr;
        req_ready_i = rdy;
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic cs, input logic [31:0] adr, input logic rdy);
        drive(cs, 1'b0, 16'h000F, adr, 1'b0, 1'b0, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_occ(input string tag, input int cnt, input logic pend);
        check({tag, " count"}, W'(count_o), W'(cnt));
        check({tag, " valid"}, W'(req_valid_o), W'(cnt != 0));
        check({tag, " full"},  W'(full_o), W'(cnt == DEPTH));
        check({tag, " empty"}, W'(empty_o), W'(cnt == 0));
        check({tag, " pend"},  W'(pend_o), W'(pend));
    endtask

    task automatic chk_head(input string tag, input logic [31:0] adr);
        check({tag, " adr_o"}, W'(adr_o), W'(adr));
        check({tag, " dato_o"}, dato_o, (empty_o === 1'b1) ? '0 : dpat(adr));
    endtask

    task automatic add(input logic cs, input logic we, input logic [SW-1:0] sel,
                       input logic [31:0] adr, input logic sr, input logic cr,
                       input logic rdy, input int e_cnt, input logic e_pend,
                       input logic e_we, input logic [SW-1:0] e_sel,
                       input logic [31:0] e_adr, input logic e_sr, input logic e_cr);
        vec_t v;
        v.cs = cs; v.we = we; v.sel = sel; v.adr = adr; v.sr = sr; v.cr = cr; v.rdy = rdy;
        v.e_cnt = e_cnt; v.e_pend = e_pend; v.e_we = e_we; v.e_sel = e_sel;
        v.e_adr = e_adr; v.e_sr = e_sr; v.e_cr = e_cr;
        vecs.push_back(v);
    endtask

    // Four bus cycles 0x0,0x10,0x20,0x30 into an empty queue with ready low.
    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i * 16), 1'b0);
            step(1'b0, 32'h0, 1'b0);
        end
        chk_occ("fill4", 4, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_occ("reset", 0, 1'b0);
        chk_head("reset", 32'h0);
        check("reset we_o", W'(we_o), '0);
        check("reset sel_o", W'(sel_o), '0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Held cycle: exactly one entry, then drained.
        for (int i = 0; i < 5; i++)
            add(1, 1, 16'hFFFF, 32'h1000, 0, 0, 0, 1, 0, 1, 16'hFFFF, 32'h1000, 0, 0);
        add(0, 0, 16'h0000, 32'h0, 0, 0, 1, 0, 0, 0, 16'h0000, 32'h0, 0, 0);
        // Four cycles to full, then back-to-back pops.
        add(1, 0, 16'h000F, 32'h00, 0, 0, 0, 1, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(0, 0, 16'h000F, 32'h00, 0, 0, 0, 1, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(1, 0, 16'h000F, 32'h10, 0, 0, 0, 2, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(0, 0, 16'h000F, 32'h10, 0, 0, 0, 2, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(1, 0, 16'h000F, 32'h20, 0, 0, 0, 3, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(0, 0, 16'h000F, 32'h20, 0, 0, 0, 3, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(1, 0, 16'h000F, 32'h30, 0, 0, 0, 4, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(0, 0, 16'h000F, 32'h30, 0, 0, 0, 4, 0, 0, 16'h000F, 32'h00, 0, 0);
        add(0, 0, 16'h000F, 32'h00, 0, 0, 1, 3, 0, 0, 16'h000F, 32'h10, 0, 0);
        add(0, 0, 16'h000F, 32'h00, 0, 0, 1, 2, 0, 0, 16'h000F, 32'h20, 0, 0);
        add(0, 0, 16'h000F, 32'h00, 0, 0, 1, 1, 0, 0, 16'h000F, 32'h30, 0, 0);
        add(0, 0, 16'h000F, 32'h00, 0, 0, 1, 0, 0, 0, 16'h0000, 32'h00, 0, 0);
        // Steady stream with ready held high: sr/cr carried, count never above 1.
        add(1, 1, 16'h00F0, 32'h100, 1, 0, 1, 1, 0, 1, 16'h00F0, 32'h100, 1, 0);
        add(0, 0, 16'h0000, 32'h0,   0, 0, 1, 0, 0, 0, 16'h0000, 32'h0,   0, 0);
        add(1, 0, 16'h0F00, 32'h110, 0, 1, 1, 1, 0, 0, 16'h0F00, 32'h110, 0, 1);
        add(0, 0, 16'h0000, 32'h0,   0, 0, 1, 0, 0, 0, 16'h0000, 32'h0,   0, 0);
        add(1, 1, 16'hF000, 32'h120, 1, 1, 1, 1, 0, 1, 16'hF000, 32'h120, 1, 1);
        add(0, 0, 16'h0000, 32'h0,   0, 0, 1, 0, 0, 0, 16'h0000, 32'h0,   0, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].cs, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].sr,
                  vecs[i].cr, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk_occ(tag, vecs[i].e_cnt, vecs[i].e_pend);
            chk_head(tag, vecs[i].e_adr);
            check({tag, " we_o"},  W'(we_o),  W'(vecs[i].e_we));
            check({tag, " sel_o"}, W'(sel_o), W'(vecs[i].e_sel));
            check({tag, " sr_o"},  W'(sr_o),  W'(vecs[i].e_sr));
            check({tag, " cr_o"},  W'(cr_o),  W'(vecs[i].e_cr));
        end

        // Pending while full, then simultaneous pop and push.
        fill4();
        step(1'b1, 32'h40, 1'b0);
        chk_occ("pend set", 4, 1'b1);
        step(1'b1, 32'h40, 1'b0);
        chk_occ("pend hold", 4, 1'b1);
        step(1'b1, 32'h40, 1'b1);
        chk_occ("push+pop", 4, 1'b0);
        chk_head("push+pop", 32'h10);
        step(1'b1, 32'h40, 1'b0);
        chk_occ("no dup", 4, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_head("drain1", 32'h20);
        step(1'b0, 32'h0, 1'b1);
        chk_head("drain2", 32'h30);
        step(1'b0, 32'h0, 1'b1);
        chk_head("drain3", 32'h40);
        chk_occ("drain3", 1, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_occ("drained", 0, 1'b0);
        chk_head("drained", 32'h0);

        // Pending cycle abandoned before space frees.
        fill4();
        step(1'b1, 32'h40, 1'b0);
        chk_occ("abandon set", 4, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk_occ("abandon clr", 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abandon head%0d", i), W'(adr_o), W'(i * 16));
            step(1'b0, 32'h0, 1'b1);
        end
        chk_occ("abandon end", 0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_occ("abandon none", 0, 1'b0);

        // Asynchronous reset mid-operation with cs_i still high.
        fill4();
        step(1'b1, 32'h50, 1'b0);
        chk_occ("pre-reset", 4, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        chk_occ("async reset", 0, 1'b0);
        chk_head("async reset", 32'h0);
        #2;
        rstn = 1'b1;
        step(1'b1, 32'h60, 1'b0);
        chk_occ("post-reset", 1, 1'b0);
        chk_head("post-reset", 32'h60);
        step(1'b1, 32'h60, 1'b0);
        chk_occ("post-reset hold", 1, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_occ("post-reset drain", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
